calc2_req_issuer: RTL
=====================

// Module: calc2_req_issuer
// PURPOSE
//  Per-port command issuer feeding one calc2 DUT port (req/data/tag in, res/out_data/out_tag back).
//  - Takes whole commands (cmd, op1, op2) over valid/ready.
//  - Allocates a free 2-bit tag and drives the two-cycle calc2 request sequence.
//  - Tracks outstanding tags and retires each on the matching DUT response.
//  - Emits one completion record per retired command.
//  One instance per DUT port (A..D), clocked by c_clk.
// PARAMETERS
//  DATA_W           32  operand/result width
//  TAG_W            2   tag width; NUM_TAGS = 2**TAG_W
//  MAX_OUTSTANDING  4   max tags in flight, 1..NUM_TAGS
// PORTS
//  c_clk        in   1       clock, all logic on posedge
//  reset        in   1       synchronous, active-high reset
//  in_valid     in   1       command offered
//  in_ready     out  1       command accepted when in_valid & in_ready
//  in_cmd       in   [0:3]   0 nop, 1 add, 2 sub, 5 shl, 6 shr
//  in_op1       in   [0:31]  operand 1
//  in_op2       in   [0:31]  operand 2
//  req_out      out  [0:3]   to DUT req_X
//  data_out     out  [0:31]  to DUT data_X1
//  tag_out      out  [0:1]   to DUT tag_X
//  res_in       in   [0:1]   DUT res_X: 0 none, 1 ok, 2 over/underflow or invalid
//  out_data_in  in   [0:31]  DUT out_Data_X
//  out_tag_in   in   [0:1]   DUT out_tag_X
//  cmpl_valid   out  1       1-cycle completion pulse
//  cmpl_tag     out  [0:1]   retired tag
//  cmpl_cmd     out  [0:3]   command stored for that tag
//  cmpl_resp    out  [0:1]   res_in captured
//  cmpl_data    out  [0:31]  out_data_in captured
//  busy_tags    out  [0:3]   bit i = tag i outstanding
//  stray_resp   out  1       1-cycle pulse: response on a non-busy tag
// BEHAVIOUR
//  - Reset: every output register is 0, busy_tags = 0, FSM = IDLE. Reset dominates all other events.
//  - FSM states:
//    - IDLE: accept edge with nonzero cmd -> OP2.
//    - OP2: always returns to IDLE on the next edge.
//  - in_ready = (state==IDLE) & (popcount(busy) < MAX_OUTSTANDING) & (some busy bit == 0).
//    Computed from registered state only.
//  - Accept, cmd != 0, at edge T:
//    - Allocate the lowest-index free tag t; set busy[t]; store cmd in tag table[t].
//    - Cycle T+1: req_out = cmd, data_out = op1, tag_out = t.
//    - Cycle T+2: req_out = 0, data_out = op2, tag_out = 0.
//    - Cycle T+3: data_out = 0.
//    - op2 is latched at T; in_op2 need not be held.
//  - Accept, cmd == 0: consumed silently. No tag allocated, DUT outputs stay 0, FSM stays IDLE.
//  - Commands 3, 4, 7..15 are forwarded unchanged; DUT resp 2 is reported as-is.
//  - Response: res_in != 0 at edge E.
//    - busy[out_tag_in] set: clear it; at E+1 cmpl_valid = 1 with tag, stored cmd, res_in, out_data_in.
//    - Tag not busy: stray_resp = 1 at E+1, no completion, state unchanged.
//  - Simultaneous accept and retire at one edge: the freed tag becomes allocatable from the next cycle only.
//    Accept and retire of the same tag can never coincide.
//  - Out-of-order responses are legal; retirement follows response order, not issue order.
//  - Reset mid-sequence (OP2 or tags busy): FSM -> IDLE, outputs -> 0, all tags freed.
//    Late DUT responses after reset report stray_resp.
// TESTING
//  1. Reset, then add op1=5 op2=7: tag0 issued.
//     - req_out=1/data=5/tag=0, next cycle data=7.
//     - res=1, data=12, tag=0 -> cmpl_valid, cmd=1, resp=1, data=12, busy=0000.
//  2. Four back-to-back accepted cmds with no responses: tags 0,1,2,3 in order.
//     - in_ready low in each OP2 cycle and after the 4th; busy=1111.
//  3. With 4 busy, respond tag2 then tag0 (out of order): two completions in that order.
//     - Next accept gets tag0.
//  4. Response on idle tag 3: stray_resp pulse, no cmpl_valid, busy unchanged.
//  5. Assert reset during OP2 of a sub: outputs 0, busy=0000; a later response on that tag -> stray_resp.
//  6. MAX_OUTSTANDING=2: third cmd stalls (in_ready=0) until one retire, then issues on lowest free tag.

Source files
------------

// File: rtl/calc2_req_issuer.sv
// Per-port command issuer for one calc2 DUT port: allocates a tag per command,
// drives the two-beat request, tracks outstanding tags and emits completions.
module calc2_req_issuer #(
  parameter int DATA_W          = 32,
  parameter int TAG_W           = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      c_clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_cmd,
  input  logic [DATA_W-1:0]         in_op1,
  input  logic [DATA_W-1:0]         in_op2,
  output logic [3:0]                req_out,
  output logic [DATA_W-1:0]         data_out,
  output logic [TAG_W-1:0]          tag_out,
  input  logic [1:0]                res_in,
  input  logic [DATA_W-1:0]         out_data_in,
  input  logic [TAG_W-1:0]          out_tag_in,
  output logic                      cmpl_valid,
  output logic [TAG_W-1:0]          cmpl_tag,
  output logic [3:0]                cmpl_cmd,
  output logic [1:0]                cmpl_resp,
  output logic [DATA_W-1:0]         cmpl_data,
  output logic [(1<<TAG_W)-1:0]     busy_tags,
  output logic                      stray_resp
);
  localparam int NUM_TAGS = 1 << TAG_W;

  typedef enum logic {IDLE = 1'b0, OP2 = 1'b1} state_e;

  state_e                       state_q;
  logic [NUM_TAGS-1:0]          busy_q, busy_d;
  logic [NUM_TAGS-1:0][3:0]     tag_cmd_q;
  logic [DATA_W-1:0]            op2_q;
  logic [3:0]                   req_q;
  logic [DATA_W-1:0]            data_q;
  logic [TAG_W-1:0]             tag_q;
  logic                         cmpl_valid_q, stray_q;
  logic [TAG_W-1:0]             cmpl_tag_q;
  logic [3:0]                   cmpl_cmd_q;
  logic [1:0]                   cmpl_resp_q;
  logic [DATA_W-1:0]            cmpl_data_q;

  logic [TAG_W:0]               n_busy;
  logic                         free_avail;
  logic [TAG_W-1:0]             alloc_tag;
  logic                         accept, issue, resp_hit, resp_stray;

  always_comb begin
    n_busy     = '0;
    free_avail = 1'b0;
    alloc_tag  = '0;
    for (int i = 0; i < NUM_TAGS; i++)
      n_busy = n_busy + (TAG_W+1)'(busy_q[i]);
    // Scan downward so the last hit is the lowest-index free tag.
    for (int i = NUM_TAGS-1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_avail = 1'b1;
        alloc_tag  = TAG_W'(i);
      end
    end
    in_ready   = (state_q == IDLE) && (n_busy < (TAG_W+1)'(MAX_OUTSTANDING)) && free_avail;
    accept     = in_valid && in_ready;
    issue      = accept && (in_cmd != 4'd0);
    resp_hit   = (res_in != 2'd0) && busy_q[out_tag_in];
    resp_stray = (res_in != 2'd0) && !busy_q[out_tag_in];
    // Allocation looks at busy_q, so a tag retired this edge is reusable next cycle.
    busy_d = busy_q;
    if (issue)    busy_d[alloc_tag]  = 1'b1;
    if (resp_hit) busy_d[out_tag_in] = 1'b0;
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= '0;
      tag_cmd_q    <= '0;
      op2_q        <= '0;
      req_q        <= '0;
      data_q       <= '0;
      tag_q        <= '0;
      cmpl_valid_q <= 1'b0;
      cmpl_tag_q   <= '0;
      cmpl_cmd_q   <= '0;
      cmpl_resp_q  <= '0;
      cmpl_data_q  <= '0;
      stray_q      <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      cmpl_valid_q <= resp_hit;
      cmpl_tag_q   <= resp_hit ? out_tag_in : '0;
      cmpl_cmd_q   <= resp_hit ? tag_cmd_q[out_tag_in] : 4'd0;
      cmpl_resp_q  <= resp_hit ? res_in : 2'd0;
      cmpl_data_q  <= resp_hit ? out_data_in : '0;
      stray_q      <= resp_stray;
      if (issue) tag_cmd_q[alloc_tag] <= in_cmd;
      case (state_q)
        IDLE: begin
          if (issue) begin
            state_q <= OP2;
            req_q   <= in_cmd;
            data_q  <= in_op1;
            tag_q   <= alloc_tag;
            op2_q   <= in_op2;
          end else begin
            req_q  <= '0;
            data_q <= '0;
            tag_q  <= '0;
          end
        end
        OP2: begin
          state_q <= IDLE;
          req_q   <= '0;
          data_q  <= op2_q;
          tag_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_out    = req_q;
  assign data_out   = data_q;
  assign tag_out    = tag_q;
  assign cmpl_valid = cmpl_valid_q;
  assign cmpl_tag   = cmpl_tag_q;
  assign cmpl_cmd   = cmpl_cmd_q;
  assign cmpl_resp  = cmpl_resp_q;
  assign cmpl_data  = cmpl_data_q;
  assign busy_tags  = busy_q;
  assign stray_resp = stray_q;

endmodule
